load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 63 ++++++
 rtl/load_aligner.sv | 28 ++
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared constants and helpers for the load/store unit: opcode and funct3
// codes, FSM state type, and the byte-lane helpers used for stores.
package load_store_unit_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Access size is carried in funct3[1:0] for every legal code.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b0;
    endcase
  endfunction

  // Clears the low address bits a half/word access cannot honour.
  function automatic logic [1:0] align_lo(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return {lo[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return lo;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational load extractor: selects the addressed lane of the captured
// read word and sign- or zero-extends it according to funct3.
module load_aligner
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    shifted     = rdata_i >> {addr_lo_i, 3'b000};
    load_data_o = shifted;
    case (funct3_i)
      F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data_o = {24'h0, shifted[7:0]};
      F3_HU:   load_data_o = {16'h0, shifted[15:0]};
      default: load_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one LOAD/STORE request, drives a word-aligned
// memory request until ack or timeout, and reports the result with a
// one-cycle done pulse.
// Build option: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of silently aligning them.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_wdata,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic        bus_error
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q;
  logic [15:0] timer_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_mask_q;
  logic [31:0] mem_wdata_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] rdata_q;
  logic [31:0] load_data_q;
  logic        done_q;
  logic        bus_error_q;
  logic [31:0] aligned_data;

  logic        req_is_store;
  logic        req_valid;
  logic        req_f3_ok;
  logic [1:0]  req_lo;
`ifdef MISALIGN_TRAP_EN
  logic        req_trap;
  logic        misaligned_q;
`endif

  // Decode the incoming request; only meaningful while IDLE.
  always_comb begin
    req_is_store = (opcode == OPC_STORE);
    req_valid    = start && ((opcode == OPC_LOAD) || req_is_store);
    req_f3_ok    = f3_legal(req_is_store, funct3);
`ifdef MISALIGN_TRAP_EN
    req_trap     = is_misaligned(funct3[1:0], address[1:0]);
    req_lo       = address[1:0];
`else
    req_lo       = align_lo(funct3[1:0], address[1:0]);
`endif
  end

  load_aligner u_load_aligner (
    .rdata_i    (rdata_q),
    .addr_lo_i  (addr_lo_q),
    .funct3_i   (funct3_q),
    .load_data_o(aligned_data)
  );

  // Control FSM with registered bus outputs and completion flags.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: datapath registers are reset too, so every output reads 0 while reset is low.
    if (!reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_mask_q   <= '0;
      mem_wdata_q  <= '0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      rdata_q      <= '0;
      load_data_q  <= '0;
      done_q       <= 1'b0;
      bus_error_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge.
      done_q       <= 1'b0;
      bus_error_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (!req_f3_ok) begin
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              bus_error_q <= 1'b1;
              rdata_q     <= '0;
            end
`ifdef MISALIGN_TRAP_EN
            else if (req_trap) begin
              state_q      <= ST_DONE;
              done_q       <= 1'b1;
              misaligned_q <= 1'b1;
              rdata_q      <= '0;
            end
`endif
            else begin
              state_q     <= ST_WAIT;
              timer_q     <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_is_store;
              mem_addr_q  <= {address[31:2], 2'b00};
              mem_mask_q  <= byte_mask(funct3[1:0], req_lo);
              mem_wdata_q <= lane_data(funct3[1:0], store_data);
              funct3_q    <= funct3;
              addr_lo_q   <= req_lo;
            end
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            // Stores report zero, so the captured word is zero for them.
            state_q   <= ST_DONE;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            rdata_q   <= mem_we_q ? 32'h0 : mem_rdata;
          end else if (timer_q == TIMER_LAST) begin
            state_q     <= ST_DONE;
            mem_req_q   <= 1'b0;
            done_q      <= 1'b1;
            bus_error_q <= 1'b1;
            rdata_q     <= '0;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          load_data_q <= aligned_data;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign busy      = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_mask  = mem_mask_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign bus_error = bus_error_q;
  assign load_data = (state_q == ST_DONE) ? aligned_data : load_data_q;
`ifdef MISALIGN_TRAP_EN
  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions compared against a behavioural model of the access rules.
module tb_load_store_unit;

  localparam int unsigned TO = 4;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam int K_IGN = 0, K_ERR = 1, K_TRAP = 2, K_ACC = 3;

  typedef struct {
    int          kind;
    logic        we;
    logic [31:0] waddr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] ldata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_mask;
  logic [31:0] mem_wdata;
  logic [31:0] load_data;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic        bus_error;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .opcode    (opcode),
    .funct3    (funct3),
    .address   (address),
    .store_data(store_data),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_mask  (mem_mask),
    .mem_wdata (mem_wdata),
    .load_data (load_data),
    .busy      (busy),
    .done      (done),
    .misaligned(misaligned),
    .bus_error (bus_error)
  );

  // Reference: what one request should produce, from size/offset arithmetic.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sd,
                                 input logic [31:0] rd);
    exp_t        e;
    int          size;
    bit          sgn;
    int          lo;
    logic [31:0] field;
    logic [31:0] keep;
    e.kind = K_IGN; e.we = 1'b0; e.waddr = '0; e.mask = '0; e.wdata = '0; e.ldata = '0;
    if (op != OP_LOAD && op != OP_STORE) return e;
    e.we = (op == OP_STORE);
    size = 0; sgn = 1'b0;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: size = 0;
    endcase
    if (e.we && f3 > 3'd2) size = 0;
    if (size == 0) begin
      e.kind = K_ERR;
      return e;
    end
    lo = int'(addr % 4);
    if (lo % size != 0) begin
`ifdef MISALIGN_TRAP_EN
      e.kind = K_TRAP;
      return e;
`else
      lo = lo - (lo % size);
`endif
    end
    e.kind  = K_ACC;
    e.waddr = addr - (addr % 4);
    e.mask  = 4'(((1 << size) - 1) << lo);
    if (size == 1)      e.wdata = 32'(sd[7:0]) * 32'h01010101;
    else if (size == 2) e.wdata = 32'(sd[15:0]) * 32'h00010001;
    else                e.wdata = sd;
    field = rd >> (8 * lo);
    if (size < 4) begin
      keep  = 32'((64'd1 << (8 * size)) - 64'd1);
      field = field & keep;
      if (sgn && field[8 * size - 1]) field = field | ~keep;
    end
    e.ldata = e.we ? 32'h0 : field;
    return e;
  endfunction

  // One request from IDLE; caller is positioned at a falling edge.
  task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [31:0] rd, input int ack_cyc,
                         input bit poke_done, input string name);
    exp_t        e;
    int          cyc, done_cyc, exp_dc, limit;
    bit          bus_ok;
    logic        exp_be;
    logic [31:0] exp_ld;
    e = model(op, f3, addr, sd, rd);
    exp_dc = (e.kind == K_IGN) ? -1 :
             (e.kind != K_ACC) ? 1 :
             (ack_cyc >= 1 && ack_cyc <= int'(TO)) ? ack_cyc + 1 : int'(TO) + 1;
    exp_be = (e.kind == K_ERR) || (e.kind == K_ACC && exp_dc == int'(TO) + 1 &&
             !(ack_cyc == int'(TO)));
    exp_ld = (e.kind == K_ACC && !exp_be) ? e.ldata : 32'h0;
    limit  = (e.kind == K_IGN) ? 6 : int'(TO) + 3;

    start = 1'b1; opcode = op; funct3 = f3; address = addr; store_data = sd;
    mem_rdata = $urandom;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; done_cyc = -1; bus_ok = 1'b1;
    while (done_cyc < 0 && cyc <= limit) begin
      if (done === 1'b1) begin
        done_cyc = cyc;
      end else begin
        if (e.kind == K_ACC) begin
          if ({mem_req, busy, mem_we, mem_addr, mem_mask, mem_wdata} !==
              {2'b11, e.we, e.waddr, e.mask, e.wdata}) bus_ok = 1'b0;
        end else if (mem_req !== 1'b0 || busy !== 1'b0) begin
          bus_ok = 1'b0;
        end
        mem_ack   = (cyc == ack_cyc);
        mem_rdata = (cyc == ack_cyc) ? rd : $urandom;
        opcode = 7'($urandom); funct3 = 3'($urandom); address = $urandom; store_data = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        cyc++;
      end
    end

    n_cmp++;
    if (bus_ok !== 1'b1) begin
      n_bad++; $display("FAIL %s bus_signals: wrong mem_* while waiting, required kind %0d", name, e.kind);
    end
    n_cmp++;
    if (done_cyc !== exp_dc) begin
      n_bad++; $display("FAIL %s done_cycle: got %0d required %0d", name, done_cyc, exp_dc);
    end
    if (done_cyc > 0) begin
      n_cmp++;
      if ({mem_req, bus_error, misaligned, load_data} !== {1'b0, exp_be, e.kind == K_TRAP, exp_ld}) begin
        n_bad++;
        $display("FAIL %s done_flags: req/be/mis/ld %b %b %b %h required 0 %b %b %h", name,
                 mem_req, bus_error, misaligned, load_data, exp_be, e.kind == K_TRAP, exp_ld);
      end
      if (poke_done) begin
        start = 1'b1; opcode = OP_LOAD; funct3 = 3'd2; address = 32'h7000;
      end
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if ({mem_req, done, bus_error, misaligned, load_data} !== {4'b0000, exp_ld}) begin
        n_bad++;
        $display("FAIL %s after_done: req/done/be/mis %b%b%b%b ld %h required 0000 ld %h", name,
                 mem_req, done, bus_error, misaligned, load_data, exp_ld);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; opcode = '0; funct3 = '0; address = '0;
    store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_we, mem_addr, mem_mask, mem_wdata, load_data, busy, done, misaligned, bus_error} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: req %b addr %h ld %h required all zero", mem_req, mem_addr, load_data);
    end
    reset = 1'b1;
  endtask

  task automatic test_directed;
    run_txn(OP_STORE, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 1, 1'b0, "sb_1003");
    run_txn(OP_LOAD,  3'd0, 32'h0000_2002, 32'h0, 32'h0080_FF00, 1, 1'b0, "lb_2002");
    run_txn(OP_LOAD,  3'd4, 32'h0000_2002, 32'h0, 32'h0080_FF00, 1, 1'b0, "lbu_2002");
    run_txn(OP_LOAD,  3'd2, 32'h0000_3000, 32'h0, 32'h1234_5678, -1, 1'b0, "lw_timeout");
    run_txn(OP_LOAD,  3'd2, 32'h0000_3004, 32'h0, 32'hCAFE_F00D, int'(TO), 1'b0, "lw_ack_last");
    run_txn(OP_LOAD,  3'd1, 32'h0000_4001, 32'h0, 32'h8001_8002, 2, 1'b0, "lh_4001");
    run_txn(OP_LOAD,  3'd5, 32'h0000_4002, 32'h0, 32'h8001_8002, 3, 1'b0, "lhu_4002");
    run_txn(OP_STORE, 3'd1, 32'h0000_4002, 32'h0000_BEEF, 32'h0, 2, 1'b0, "sh_4002");
    run_txn(OP_JAL,   3'd2, 32'h0000_5000, 32'h0, 32'h0, 2, 1'b0, "jal_ignored");
    run_txn(OP_LOAD,  3'd7, 32'h0000_5000, 32'h0, 32'h0, 1, 1'b0, "load_f3_7");
    run_txn(OP_STORE, 3'd4, 32'h0000_5000, 32'h0, 32'h0, 1, 1'b0, "store_f3_4");
  endtask

  task automatic test_back_to_back;
    run_txn(OP_LOAD,  3'd2, 32'h0000_6000, 32'h0, 32'hA5A5_0001, 1, 1'b1, "b2b_poke_done");
    run_txn(OP_STORE, 3'd2, 32'h0000_6004, 32'h1111_2222, 32'h0, 1, 1'b1, "b2b_sw");
    run_txn(OP_LOAD,  3'd0, 32'h0000_6007, 32'h0, 32'h7F00_0000, 2, 1'b0, "b2b_lb");
  endtask

  task automatic test_random;
    logic [6:0] op;
    int         sel;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      op  = (sel < 4) ? OP_LOAD : (sel < 8) ? OP_STORE : (sel == 8) ? OP_JAL : 7'($urandom);
      run_txn(op, 3'($urandom), $urandom, $urandom, $urandom,
              $urandom_range(1, int'(TO) + 1), 1'($urandom), $sformatf("rand_%0d", i));
    end
  endtask

  task automatic test_reset_mid_wait;
    bit seen_done;
    start = 1'b1; opcode = OP_LOAD; funct3 = 3'd2; address = 32'h0000_5000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_bad++; $display("FAIL rst_pre_wait: mem_req %b required 1", mem_req);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, busy, done, mem_mask, mem_addr, load_data} !== '0) begin
      n_bad++; $display("FAIL rst_mid_wait: req %b busy %b addr %h required 0", mem_req, busy, mem_addr);
    end
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done !== 1'b0) begin
      n_bad++; $display("FAIL rst_no_done: done seen %b required 0", seen_done);
    end
    reset = 1'b1;
    run_txn(OP_STORE, 3'd2, 32'h0000_6004, 32'hDEAD_BEEF, 32'h0, 2, 1'b0, "sw_after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
